// File: rtl/xbar_periph_bus_mux.sv
// N-to-1 round-robin multiplexer for the peripheral request/grant bus.
// A small in-order FIFO of master indices steers each slave response back to its requester.
module xbar_periph_bus_mux #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 6,
  parameter int MAX_OUTSTANDING = 2,
  localparam int BE_WIDTH       = DATA_WIDTH / 8,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_MASTERS-1:0]            m_req_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_add_i,
  input  logic [N_MASTERS-1:0]            m_wen_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [N_MASTERS*BE_WIDTH-1:0]   m_be_i,
  input  logic [N_MASTERS*ID_WIDTH-1:0]   m_id_i,
  output logic [N_MASTERS-1:0]            m_gnt_o,
  output logic [N_MASTERS-1:0]            m_r_valid_o,
  output logic [N_MASTERS*DATA_WIDTH-1:0] m_r_rdata_o,
  output logic [N_MASTERS*ID_WIDTH-1:0]   m_r_id_o,
  output logic [N_MASTERS-1:0]            m_r_opc_o,
  output logic                            s_req_o,
  output logic [ADDR_WIDTH-1:0]           s_add_o,
  output logic                            s_wen_o,
  output logic [DATA_WIDTH-1:0]           s_wdata_o,
  output logic [BE_WIDTH-1:0]             s_be_o,
  output logic [ID_WIDTH-1:0]             s_id_o,
  input  logic                            s_gnt_i,
  input  logic                            s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]           s_r_rdata_i,
  input  logic [ID_WIDTH-1:0]             s_r_id_i,
  input  logic                            s_r_opc_i,
  output logic [CNT_WIDTH-1:0]            outstanding_o,
  output logic                            spurious_o
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     winner;
  logic                 any_req;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [IDX_W-1:0]     head;
  logic                 spurious;
  logic [IDX_W-1:0]     fifo_mem [MAX_OUTSTANDING];

  // First requester at or above rr_ptr, wrapping past the top master.
  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_MASTERS))
        cand = cand - (IDX_W+1)'(N_MASTERS);
      if (!found && m_req_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req = |m_req_i;
  assign full    = (count == CNT_WIDTH'(MAX_OUTSTANDING));
  assign empty   = (count == '0);
  // Gating with rst_ni keeps every grant low while reset is held.
  assign s_req_o = rst_ni && any_req && !full;
  assign push    = s_req_o && s_gnt_i;
  assign pop     = s_r_valid_i && !empty;
  assign head    = fifo_mem[rd_ptr];

  always_comb begin
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    s_id_o    = '0;
    if (s_req_o) begin
      s_add_o   = m_add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_wen_o   = m_wen_i[winner];
      s_wdata_o = m_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      s_be_o    = m_be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
      s_id_o    = m_id_i[int'(winner)*ID_WIDTH +: ID_WIDTH];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign m_gnt_o[gi]                               = push && (winner == IDX_W'(gi));
      assign m_r_valid_o[gi]                           = pop && (head == IDX_W'(gi));
      assign m_r_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH]  = s_r_rdata_i;
      assign m_r_id_o[gi*ID_WIDTH +: ID_WIDTH]         = s_r_id_i;
      assign m_r_opc_o[gi]                             = s_r_opc_i;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      spurious <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (winner == IDX_W'(N_MASTERS-1)) ? '0 : winner + IDX_W'(1);
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr + PTR_W'(1);
      // A response finding nothing in flight is dropped but remembered.
      if (s_r_valid_i && empty)
        spurious <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  assign outstanding_o = count;
  assign spurious_o    = spurious;

endmodule

// File: tb/tb_xbar_periph_bus_mux.sv
// Bench for xbar_periph_bus_mux: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_xbar_periph_bus_mux;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IW = 6;
  localparam int MO = 2;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req, m_wen, m_gnt, m_r_valid, m_r_opc;
  logic [N*AW-1:0] m_add;
  logic [N*DW-1:0] m_wdata, m_r_rdata;
  logic [N*BW-1:0] m_be;
  logic [N*IW-1:0] m_id, m_r_id;
  logic            s_req, s_wen, s_gnt, s_r_valid, s_r_opc;
  logic [AW-1:0]   s_add;
  logic [DW-1:0]   s_wdata, s_r_rdata;
  logic [BW-1:0]   s_be;
  logic [IW-1:0]   s_id, s_r_id;
  logic [CW-1:0]   outstanding;
  logic            spurious;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  int           mdl_rr;
  int           mdl_q[$];
  bit           mdl_spur;
  int           exp_win;
  logic         exp_sreq;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_rv;

  always #5 clk = ~clk;

  xbar_periph_bus_mux #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata),
    .m_be_i(m_be), .m_id_i(m_id),
    .m_gnt_o(m_gnt), .m_r_valid_o(m_r_valid), .m_r_rdata_o(m_r_rdata),
    .m_r_id_o(m_r_id), .m_r_opc_o(m_r_opc),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata),
    .s_be_o(s_be), .s_id_o(s_id), .s_gnt_i(s_gnt),
    .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata), .s_r_id_i(s_r_id), .s_r_opc_i(s_r_opc),
    .outstanding_o(outstanding), .spurious_o(spurious)
  );

  function automatic void model_reset();
    mdl_rr = 0;
    mdl_q.delete();
    mdl_spur = 1'b0;
  endfunction

  function automatic void model_eval();
    exp_win = -1;
    for (int k = 0; k < N; k++)
      if (exp_win < 0 && m_req[(mdl_rr + k) % N]) exp_win = (mdl_rr + k) % N;
    exp_sreq = (exp_win >= 0) && (mdl_q.size() < MO);
    exp_gnt  = (exp_sreq && s_gnt) ? (N'(1) << exp_win) : '0;
    exp_rv   = (s_r_valid && mdl_q.size() > 0) ? (N'(1) << mdl_q[0]) : '0;
  endfunction

  function automatic void model_edge();
    if (s_r_valid) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      else mdl_spur = 1'b1;
    end
    if (exp_gnt != '0) begin
      mdl_q.push_back(exp_win);
      mdl_rr = (exp_win + 1) % N;
    end
  endfunction

  // Advance one cycle from a falling edge to the next, keeping the model in step.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_req = '0; m_add = '0; m_wen = '0; m_wdata = '0; m_be = '0; m_id = '0;
    s_gnt = 1'b0; s_r_valid = 1'b0; s_r_rdata = '0; s_r_id = '0; s_r_opc = 1'b0;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] add, input logic wen,
                            input logic [DW-1:0] wd, input logic [BW-1:0] be,
                            input logic [IW-1:0] id);
    m_req[i] = 1'b1;
    m_add[i*AW +: AW] = add;
    m_wen[i] = wen;
    m_wdata[i*DW +: DW] = wd;
    m_be[i*BW +: BW] = be;
    m_id[i*IW +: IW] = id;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    set_master(0, 16'h0040, 1'b1, '0, 4'hF, 6'd1);
    s_gnt = 1'b1;
    s_r_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks_total++; if (m_gnt !== '0) $display("FAIL reset_gnt: got %b want 0000", m_gnt); else checks_passed++;
    checks_total++; if (m_r_valid !== '0) $display("FAIL reset_rvalid: got %b want 0000", m_r_valid); else checks_passed++;
    checks_total++; if (outstanding !== '0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else checks_passed++;
    checks_total++; if (spurious !== 1'b0) $display("FAIL reset_spurious: got %b want 0", spurious); else checks_passed++;
    $display("reset: gnt=%b r_valid=%b outstanding=%0d spurious=%b", m_gnt, m_r_valid, outstanding, spurious);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_master(0, 16'h0100, 1'b1, '0, 4'hF, 6'd3);
    s_gnt = 1'b1;
    #1;
    checks_total++; if (m_gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", m_gnt); else checks_passed++;
    checks_total++; if (s_add !== 16'h0100 || s_wen !== 1'b1) $display("FAIL single_req: got add=%h wen=%b want 0100/1", s_add, s_wen); else checks_passed++;
    tick();
    m_req = '0; s_gnt = 1'b0;
    #1;
    checks_total++; if (outstanding !== 2'd1) $display("FAIL single_out1: got %0d want 1", outstanding); else checks_passed++;
    checks_total++; if (m_r_valid !== '0) $display("FAIL single_early_rv: got %b want 0000", m_r_valid); else checks_passed++;
    tick();
    s_r_valid = 1'b1; s_r_rdata = 32'hDEADBEEF; s_r_id = 6'd5;
    #1;
    checks_total++; if (m_r_valid !== 4'b0001) $display("FAIL single_rv: got %b want 0001", m_r_valid); else checks_passed++;
    checks_total++; if (m_r_rdata[0 +: DW] !== 32'hDEADBEEF || m_r_rdata[3*DW +: DW] !== 32'hDEADBEEF)
      $display("FAIL single_rdata: got %h/%h want deadbeef", m_r_rdata[0 +: DW], m_r_rdata[3*DW +: DW]); else checks_passed++;
    checks_total++; if (m_r_id[0 +: IW] !== 6'd5) $display("FAIL single_rid: got %0d want 5", m_r_id[0 +: IW]); else checks_passed++;
    tick();
    s_r_valid = 1'b0;
    #1;
    checks_total++; if (outstanding !== 2'd0) $display("FAIL single_out0: got %0d want 0", outstanding); else checks_passed++;
    $display("single: response delivered, outstanding=%0d", outstanding);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_master(i, AW'(16'h0200 + i), 1'b1, '0, 4'hF, IW'(i));
    s_gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) m_req = '0;
      s_r_valid = (c > 0);
      s_r_id = IW'(c);
      #1;
      if (c < 5) begin
        checks_total++; if (m_gnt !== (4'(1) << (c % 4))) $display("FAIL rr_gnt%0d: got %b want %b", c, m_gnt, 4'(1) << (c % 4)); else checks_passed++;
      end
      if (c > 0) begin
        checks_total++; if (m_r_valid !== (4'(1) << ((c - 1) % 4))) $display("FAIL rr_rv%0d: got %b want %b", c, m_r_valid, 4'(1) << ((c - 1) % 4)); else checks_passed++;
      end
      $display("round_robin cycle %0d: gnt=%b r_valid=%b", c, m_gnt, m_r_valid);
      tick();
    end
    s_r_valid = 1'b0;
    #1;
    checks_total++; if (outstanding !== 2'd0) $display("FAIL rr_drain: got %0d want 0", outstanding); else checks_passed++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_master(2, 16'h0300, 1'b0, 32'h1234_5678, 4'h3, 6'd9);
    s_gnt = 1'b1;
    #1;
    checks_total++; if (m_gnt !== 4'b0100) $display("FAIL bp_gnt0: got %b want 0100", m_gnt); else checks_passed++;
    tick(); #1;
    checks_total++; if (m_gnt !== 4'b0100 || outstanding !== 2'd1) $display("FAIL bp_gnt1: got %b/%0d want 0100/1", m_gnt, outstanding); else checks_passed++;
    tick(); #1;
    checks_total++; if (s_req !== 1'b0 || m_gnt !== '0 || outstanding !== 2'd2)
      $display("FAIL bp_full: got req=%b gnt=%b out=%0d want 0/0000/2", s_req, m_gnt, outstanding); else checks_passed++;
    tick();
    s_r_valid = 1'b1;
    #1;
    checks_total++; if (m_r_valid !== 4'b0100 || s_req !== 1'b0)
      $display("FAIL bp_pop_full: got rv=%b req=%b want 0100/0", m_r_valid, s_req); else checks_passed++;
    tick();
    s_r_valid = 1'b0;
    #1;
    checks_total++; if (outstanding !== 2'd1 || s_req !== 1'b1 || m_gnt !== 4'b0100)
      $display("FAIL bp_regrant: got out=%0d req=%b gnt=%b want 1/1/0100", outstanding, s_req, m_gnt); else checks_passed++;
    $display("back_pressure: regrant after slot freed, outstanding=%0d", outstanding);
    tick();
    m_req = '0; s_r_valid = 1'b1;
    repeat (2) tick();
    s_r_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    set_master(1, 16'h0ABC, 1'b1, '0, 4'hF, 6'd2);
    s_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks_total++; if (s_add !== 16'h0ABC || m_gnt !== '0)
        $display("FAIL stall%0d: got add=%h gnt=%b want 0abc/0000", c, s_add, m_gnt); else checks_passed++;
      tick();
    end
    set_master(0, 16'h0123, 1'b1, '0, 4'hF, 6'd4);
    #1;
    checks_total++; if (s_add !== 16'h0123) $display("FAIL stall_rr_hold: got add=%h want 0123", s_add); else checks_passed++;
    tick();
    s_gnt = 1'b1;
    #1;
    checks_total++; if (m_gnt !== 4'b0001) $display("FAIL stall_gnt_m0: got %b want 0001", m_gnt); else checks_passed++;
    tick();
    m_req[0] = 1'b0;
    #1;
    checks_total++; if (m_gnt !== 4'b0010) $display("FAIL stall_gnt_m1: got %b want 0010", m_gnt); else checks_passed++;
    $display("stall: m1 granted after stall, gnt=%b", m_gnt);
    tick();
    m_req = '0; s_gnt = 1'b0; s_r_valid = 1'b1;
    repeat (2) tick();
    s_r_valid = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    s_r_valid = 1'b1; s_r_rdata = 32'hCAFE_F00D;
    #1;
    checks_total++; if (m_r_valid !== '0) $display("FAIL spur_rv: got %b want 0000", m_r_valid); else checks_passed++;
    tick();
    s_r_valid = 1'b0;
    #1;
    checks_total++; if (spurious !== 1'b1) $display("FAIL spur_set: got %b want 1", spurious); else checks_passed++;
    repeat (3) tick();
    #1;
    checks_total++; if (spurious !== 1'b1) $display("FAIL spur_sticky: got %b want 1", spurious); else checks_passed++;
    $display("spurious: flag=%b", spurious);
  endtask

  task automatic test_reset_midop();
    do_reset();
    s_r_valid = 1'b1;
    tick();
    s_r_valid = 1'b0;
    set_master(0, 16'h0500, 1'b1, '0, 4'hF, 6'd7);
    s_gnt = 1'b1;
    repeat (2) tick();
    #1;
    checks_total++; if (outstanding !== 2'd2 || spurious !== 1'b1)
      $display("FAIL midop_pre: got out=%0d spur=%b want 2/1", outstanding, spurious); else checks_passed++;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    checks_total++; if (outstanding !== 2'd0 || spurious !== 1'b0)
      $display("FAIL midop_reset: got out=%0d spur=%b want 0/0", outstanding, spurious); else checks_passed++;
    @(negedge clk);
    rst_n = 1'b1;
    s_r_valid = 1'b1;
    #1;
    checks_total++; if (m_r_valid !== '0) $display("FAIL midop_stale_rv: got %b want 0000", m_r_valid); else checks_passed++;
    tick();
    s_r_valid = 1'b0;
    #1;
    checks_total++; if (spurious !== 1'b1) $display("FAIL midop_stale_spur: got %b want 1", spurious); else checks_passed++;
    $display("reset_midop: outstanding=%0d spurious=%b", outstanding, spurious);
  endtask

  task automatic test_random();
    logic [AW-1:0] e_add;
    logic [IW-1:0] e_id;
    logic [DW-1:0] e_wd;
    int            probe;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!m_req[i] && $urandom_range(0, 1) == 1)
          set_master(i, AW'($urandom), 1'($urandom), $urandom, BW'($urandom), IW'($urandom));
      s_gnt     = ($urandom_range(0, 3) != 0);
      s_r_valid = ($urandom_range(0, 2) == 0);
      s_r_rdata = $urandom;
      s_r_id    = IW'($urandom);
      s_r_opc   = 1'($urandom);
      model_eval();
      e_add = '0; e_id = '0; e_wd = '0;
      if (exp_sreq) begin
        e_add = m_add[exp_win*AW +: AW];
        e_id  = m_id[exp_win*IW +: IW];
        e_wd  = m_wdata[exp_win*DW +: DW];
      end
      probe = $urandom_range(0, N - 1);
      #1;
      checks_total++; if (m_gnt !== exp_gnt) $display("FAIL rnd_gnt c%0d: got %b want %b", c, m_gnt, exp_gnt); else checks_passed++;
      checks_total++; if (m_r_valid !== exp_rv) $display("FAIL rnd_rv c%0d: got %b want %b", c, m_r_valid, exp_rv); else checks_passed++;
      checks_total++; if (s_req !== exp_sreq || s_add !== e_add || s_id !== e_id || s_wdata !== e_wd)
        $display("FAIL rnd_sreq c%0d: got %b/%h/%h/%h want %b/%h/%h/%h", c, s_req, s_add, s_id, s_wdata, exp_sreq, e_add, e_id, e_wd); else checks_passed++;
      checks_total++; if (outstanding !== CW'(mdl_q.size()) || spurious !== mdl_spur)
        $display("FAIL rnd_state c%0d: got out=%0d spur=%b want %0d/%b", c, outstanding, spurious, mdl_q.size(), mdl_spur); else checks_passed++;
      checks_total++; if (m_r_rdata[probe*DW +: DW] !== s_r_rdata || m_r_opc[probe] !== s_r_opc)
        $display("FAIL rnd_bcast c%0d: got %h want %h", c, m_r_rdata[probe*DW +: DW], s_r_rdata); else checks_passed++;
      $display("random c%0d: req=%b gnt=%b r_valid=%b out=%0d", c, m_req, m_gnt, m_r_valid, outstanding);
      tick();
      for (int i = 0; i < N; i++) if (exp_gnt[i]) m_req[i] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_stall();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
